// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: FSM state codes and default sizing shared by the PWM capture block
package pwm_capture_pkg;
    localparam int CNT_W_DEF       = 16;
    localparam int TIMEOUT_CYC_DEF = 20000;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HIGH  = 2'd1;
    localparam logic [1:0] ST_LOW   = 2'd2;
    localparam logic [1:0] ST_STUCK = 2'd3;
endpackage

// File: rtl/pwm_capture_sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus history flop producing level and single-cycle rise/fall strobes
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, hist;
    // history always tracks the synchronizer, so re-enabling never sees a stale edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {s1, s2, hist} <= '0;
        else {s1, s2, hist} <= {din, s1, s2};
    assign level = s2;
    assign rise  = ena & s2 & ~hist;
    assign fall  = ena & ~s2 & hist;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input, flags a stuck-high/stuck-low input
module pwm_capture import pwm_capture_pkg::*; #(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck_hi,
    output logic             stuck_lo
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic             level, rise, fall, edge_any, timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] hcnt, pcnt, hinc, pinc;
    logic [TW-1:0]    tcnt;
    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .din   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );
    assign edge_any = rise | fall;
    assign hinc     = &hcnt ? hcnt : hcnt + 1'b1;
    assign pinc     = &pcnt ? pcnt : pcnt + 1'b1;
    // an edge in the same cycle always wins over the timeout
    assign timeout  = state != ST_STUCK && !edge_any && tcnt == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= ST_IDLE;
            hcnt       <= '0;
            pcnt       <= '0;
            tcnt       <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            meas_valid <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else if (!ena) begin
            state      <= ST_IDLE;
            hcnt       <= '0;
            pcnt       <= '0;
            tcnt       <= '0;
            meas_valid <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            tcnt       <= edge_any ? '0 : tcnt == TW'(TIMEOUT_CYC) ? tcnt : tcnt + 1'b1;
            if (timeout) begin
                state    <= ST_STUCK;
                stuck_hi <= level;
                stuck_lo <= !level;
            end else begin
                case (state)
                    ST_IDLE: if (rise) begin
                        state <= ST_HIGH;
                        hcnt  <= CNT_W'(1);
                        pcnt  <= CNT_W'(1);
                    end
                    ST_HIGH: begin
                        pcnt <= pinc;
                        if (fall) state <= ST_LOW;
                        else hcnt <= hinc;
                    end
                    ST_LOW: if (rise) begin
                        high_cnt   <= hcnt;
                        period_cnt <= pcnt;
                        meas_valid <= 1'b1;
                        state      <= ST_HIGH;
                        hcnt       <= CNT_W'(1);
                        pcnt       <= CNT_W'(1);
                    end else pcnt <= pinc;
                    default: if (edge_any) begin
                        stuck_hi <= 1'b0;
                        stuck_lo <= 1'b0;
                        state    <= rise ? ST_HIGH : ST_IDLE;
                        hcnt     <= CNT_W'(rise);
                        pcnt     <= CNT_W'(rise);
                    end
                endcase
            end
        end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed PWM waveforms checked against a period-level reference model
module tb_pwm_capture;
    localparam int CW   = 12;
    localparam int TO   = 20000;
    localparam int MAXV = (1 << CW) - 1;
    logic          clk = 1'b0, rst_n = 1'b0, ena = 1'b0, pwm_in = 1'b0;
    logic [CW-1:0] high_cnt, period_cnt;
    logic          meas_valid, stuck_hi, stuck_lo;
    logic          mv_q = 1'b0;
    int            ncmp = 0, nfail = 0;
    int            exp_h[$], exp_p[$];
    bit            have_prev = 0;
    int            prev_h = 0, prev_l = 0;

    pwm_capture #(.CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .stuck_hi   (stuck_hi),
        .stuck_lo   (stuck_lo)
    );

    always #50 clk = ~clk;

    function automatic int sat(input int v);
        return v > MAXV ? MAXV : v;
    endfunction

    // every publish must match the oldest completed period the model has queued
    always @(negedge clk) begin
        ncmp++;
        if (stuck_hi && stuck_lo) begin
            nfail++;
            $display("FAIL stuck_excl: stuck_hi=%0b stuck_lo=%0b, required not both 1", stuck_hi, stuck_lo);
        end
        if (meas_valid && mv_q) begin
            nfail++;
            $display("FAIL mv_width: meas_valid high two cycles in a row, required one-cycle pulse");
        end
        if (meas_valid) begin
            ncmp++;
            if (exp_h.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_mv: got high=%0d period=%0d, required no meas_valid", high_cnt, period_cnt);
            end else begin
                int eh, ep;
                eh = exp_h.pop_front();
                ep = exp_p.pop_front();
                if (int'(high_cnt) !== eh || int'(period_cnt) !== ep) begin
                    nfail++;
                    $display("FAIL meas: got high=%0d period=%0d, required high=%0d period=%0d", high_cnt, period_cnt, eh, ep);
                end
            end
        end
        mv_q <= meas_valid;
    end

    task automatic hold(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic wave(input int h, input int l);
        if (have_prev) begin
            exp_h.push_back(sat(prev_h));
            exp_p.push_back(sat(prev_h + prev_l));
        end
        hold(1'b1, h);
        hold(1'b0, l);
        have_prev = 1;
        prev_h = h;
        prev_l = l;
    endtask

    task automatic rise_now();
        if (have_prev) begin
            exp_h.push_back(sat(prev_h));
            exp_p.push_back(sat(prev_h + prev_l));
        end
        have_prev = 0;
        pwm_in = 1'b1;
    endtask

    task automatic final_rise();
        rise_now();
        hold(1'b1, 6);
    endtask

    task automatic check_drained(input string name);
        ncmp++;
        if (exp_h.size() != 0) begin
            nfail++;
            $display("FAIL %s_drained: %0d measurements still pending, required 0", name, exp_h.size());
        end
        exp_h.delete();
        exp_p.delete();
    endtask

    task automatic check_out(input string name, input int h, input int p, input logic sh, input logic sl);
        ncmp++;
        if (int'(high_cnt) !== h || int'(period_cnt) !== p || stuck_hi !== sh || stuck_lo !== sl) begin
            nfail++;
            $display("FAIL %s: got high=%0d period=%0d stuck_hi=%0b stuck_lo=%0b, required high=%0d period=%0d stuck_hi=%0b stuck_lo=%0b",
                     name, high_cnt, period_cnt, stuck_hi, stuck_lo, h, p, sh, sl);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena = 1'b1;
        have_prev = 0;
        hold(1'b0, 3);
        rst_n = 1'b1;
        hold(1'b0, 3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b1;
        hold(1'b1, 4);
        ncmp++;
        if (meas_valid !== 1'b0) begin
            nfail++;
            $display("FAIL reset_mv: got %0b, required 0", meas_valid);
        end
        check_out("reset_outputs", 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_symmetric();
        do_reset();
        wave(1667, 1667);
        final_rise();
        check_out("sym_values", 1667, 3334, 1'b0, 1'b0);
        check_drained("sym");
    endtask

    task automatic test_narrow();
        do_reset();
        repeat (4) wave(13, 3321);
        final_rise();
        check_out("narrow_values", 13, 3334, 1'b0, 1'b0);
        check_drained("narrow");
    endtask

    task automatic test_random();
        do_reset();
        repeat (8) wave(int'($urandom_range(1, 300)), int'($urandom_range(1, 300)));
        final_rise();
        check_drained("random");
    endtask

    task automatic test_saturation();
        do_reset();
        wave(4200, 1000);
        wave(5, 7);
        final_rise();
        check_drained("saturation");
    endtask

    task automatic test_stuck_hi();
        do_reset();
        wave(100, 100);
        rise_now();
        hold(1'b1, TO + 20);
        check_out("stuck_hi_set", 100, 200, 1'b1, 1'b0);
        check_drained("stuck_hi_pub");
        hold(1'b0, 5);
        check_out("stuck_hi_clear", 100, 200, 1'b0, 1'b0);
        wave(50, 50);
        final_rise();
        check_drained("stuck_hi_idle");
    endtask

    task automatic test_stuck_lo();
        int first;
        first = -1;
        rst_n = 1'b0;
        ena = 1'b1;
        have_prev = 0;
        hold(1'b0, 3);
        rst_n = 1'b1;
        for (int k = 1; k <= TO + 5; k++) begin
            @(negedge clk);
            if (stuck_lo && first < 0) first = k;
        end
        ncmp++;
        if (first < TO || first > TO + 3) begin
            nfail++;
            $display("FAIL stuck_lo_time: stuck_lo first seen at cycle %0d, required %0d..%0d", first, TO, TO + 3);
        end
        check_out("stuck_lo_set", 0, 0, 1'b0, 1'b1);
        wave(30, 40);
        check_out("stuck_lo_clear", 0, 0, 1'b0, 1'b0);
        final_rise();
        check_drained("stuck_lo");
    endtask

    task automatic test_ena();
        do_reset();
        wave(20, 30);
        rise_now();
        hold(1'b1, 10);
        ena = 1'b0;
        hold(1'b1, 10);
        hold(1'b0, 30);
        check_out("ena_off_hold", 20, 50, 1'b0, 1'b0);
        ena = 1'b1;
        hold(1'b0, 5);
        wave(15, 25);
        check_out("ena_on_hold", 20, 50, 1'b0, 1'b0);
        final_rise();
        check_drained("ena");
    endtask

    task automatic test_reset_mid();
        do_reset();
        wave(40, 40);
        rise_now();
        hold(1'b1, 20);
        check_drained("rst_mid_pre");
        #20 rst_n = 1'b0;
        #1;
        ncmp++;
        if (meas_valid !== 1'b0) begin
            nfail++;
            $display("FAIL rst_mid_mv: got %0b, required 0", meas_valid);
        end
        check_out("rst_mid_async", 0, 0, 1'b0, 1'b0);
        pwm_in = 1'b0;
        have_prev = 0;
        @(negedge clk);
        hold(1'b0, 3);
        rst_n = 1'b1;
        hold(1'b0, 5);
        wave(25, 35);
        check_out("rst_mid_no_pub", 0, 0, 1'b0, 1'b0);
        final_rise();
        check_drained("rst_mid");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_symmetric();
        test_narrow();
        test_random();
        test_saturation();
        test_stuck_hi();
        test_stuck_lo();
        test_ena();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
